// File: rtl/chan_scanner_if.sv
// Scanner control/status bundle: run controls in, mux select and scan strobes out.
// Scanner is master (drives sel and strobes); controller/consumer side is slave.
interface chan_scanner_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic [3:0]         chan_en;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               sel_valid;
  logic               sample;
  logic               sweep_done;
  logic               busy;

  modport master (
    input  start, stop, chan_en, dwell,
    output sel, sel_valid, sample, sweep_done, busy
  );

  modport slave (
    output start, stop, chan_en, dwell,
    input  sel, sel_valid, sample, sweep_done, busy
  );
endinterface

// File: rtl/chan_scanner.sv
// Round-robin 4:1 mux channel scanner: 1-cycle SEEK gap then dwell+1 cycles per channel, no backpressure (stop aborts).
// sel is registered; SCAN_ONESHOT_EN makes the scanner return to IDLE after one full sweep.
module chan_scanner #(
  parameter int DWELL_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  chan_scanner_if.master io_scan
);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_DWELL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_sel;
  logic [1:0]         r_ptr;
  logic [DWELL_W-1:0] r_cnt;
  logic [1:0]         w_pick;
  logic [1:0]         w_idx;
  logic               w_any_en;
  logic               w_last;
  logic               w_hi_en;
  logic               w_sweep;

  assign w_any_en = |io_scan.chan_en;
  assign w_last   = (r_state == S_DWELL) && (r_cnt == io_scan.dwell);
  // Any enabled channel strictly above the current one means the sweep is not finished.
  assign w_hi_en  = |(io_scan.chan_en >> ({1'b0, r_sel} + 3'd1));
  assign w_sweep  = w_last && !w_hi_en;

  // Descending scan so the smallest offset from the pointer wins.
  always_comb begin
    w_pick = 2'd0;
    w_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (io_scan.chan_en[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (io_scan.start && !io_scan.stop && w_any_en) begin
          w_state_nxt = S_SEEK;
        end
      end
      S_SEEK: begin
        if (io_scan.stop || !w_any_en) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DWELL;
        end
      end
      S_DWELL: begin
        if (io_scan.stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
`ifdef SCAN_ONESHOT_EN
          w_state_nxt = w_sweep ? S_IDLE : S_SEEK;
`else
          w_state_nxt = S_SEEK;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel <= 2'd0;
      r_ptr <= 2'd0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_SEEK) begin
            r_ptr <= 2'd0;
          end
        end
        S_SEEK: begin
          if (w_state_nxt == S_DWELL) begin
            r_sel <= w_pick;
            r_cnt <= '0;
          end
        end
        S_DWELL: begin
          r_cnt <= r_cnt + DWELL_W'(1);
          if (w_last) begin
            r_ptr <= r_sel + 2'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    io_scan.sel        = r_sel;
    io_scan.sel_valid  = (r_state == S_DWELL);
    io_scan.sample     = w_last;
    io_scan.sweep_done = w_sweep;
    io_scan.busy       = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_chan_scanner.sv
// Directed bench for chan_scanner; observes {sel, sel_valid, sample, sweep_done, busy} on the falling edge.
module tb_chan_scanner;

  logic       clk;
  logic       rst;
  logic       mux_a, mux_b, mux_c, mux_d;
  logic       mux_out;
  logic [5:0] obs;
  logic [5:0] exp_v;
  int         n_chk;
  int         n_pass;

  chan_scanner_if #(.DWELL_W(4)) sif ();

  chan_scanner #(.DWELL_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_scan (sif)
  );

  always #5 clk = ~clk;

  assign obs = {sif.sel, sif.sel_valid, sif.sample, sif.sweep_done, sif.busy};

  // Behavioural stand-in for the downstream 4:1 select mux.
  always_comb begin
    case (sif.sel)
      2'd0:    mux_out = mux_a;
      2'd1:    mux_out = mux_b;
      2'd2:    mux_out = mux_c;
      default: mux_out = mux_d;
    endcase
  end

  function automatic logic [5:0] ev(input logic [1:0] s, input logic v, input logic sm,
                                    input logic sd, input logic b);
    return {s, v, sm, sd, b};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic halt();
    sif.stop = 1'b1;
    step();
    sif.stop = 1'b0;
  endtask

  task automatic kick();
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.start = 1'b1;
    sif.chan_en = 4'b1111;
    step();
    step();
    exp_v = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL reset_outputs got %b exp %b", obs, exp_v); else n_pass++;
    sif.start = 1'b0;
    rst = 1'b0;
    step();
    n_chk++; if (obs !== exp_v) $display("FAIL reset_release_idle got %b exp %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_dwell0();
    sif.chan_en = 4'b1111;
    sif.dwell = 4'd0;
    kick();
    exp_v = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL dw0_first_seek got %b exp %b", obs, exp_v); else n_pass++;
    for (int ch = 0; ch < 4; ch++) begin
      step();
      exp_v = ev(2'(ch), 1'b1, 1'b1, (ch == 3), 1'b1);
      n_chk++; if (obs !== exp_v) $display("FAIL dw0_dwell ch%0d got %b exp %b", ch, obs, exp_v); else n_pass++;
      if (ch < 3) begin
        step();
        exp_v = ev(2'(ch), 1'b0, 1'b0, 1'b0, 1'b1);
        n_chk++; if (obs !== exp_v) $display("FAIL dw0_gap ch%0d got %b exp %b", ch, obs, exp_v); else n_pass++;
      end
    end
    step();
`ifdef SCAN_ONESHOT_EN
    exp_v = ev(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL dw0_oneshot_idle got %b exp %b", obs, exp_v); else n_pass++;
    halt();
`else
    exp_v = ev(2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL dw0_wrap_gap got %b exp %b", obs, exp_v); else n_pass++;
    step();
    exp_v = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL dw0_wrap_ch0 got %b exp %b", obs, exp_v); else n_pass++;
    sif.stop = 1'b1;
    #1;
    n_chk++; if (sif.sample !== 1'b1) $display("FAIL stop_with_sample got %b exp 1", sif.sample); else n_pass++;
    step();
    sif.stop = 1'b0;
    exp_v = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL stop_last_cycle_idle got %b exp %b", obs, exp_v); else n_pass++;
`endif
  endtask

  task automatic test_skip_dwell();
    sif.chan_en = 4'b0101;
    sif.dwell = 4'd3;
    kick();
    n_chk++; if (obs[3:0] !== 4'b0001) $display("FAIL skip_seek got %b exp 0001", obs[3:0]); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_v = ev(2'd0, 1'b1, (k == 3), 1'b0, 1'b1);
      n_chk++; if (obs !== exp_v) $display("FAIL skip_ch0 cyc%0d got %b exp %b", k, obs, exp_v); else n_pass++;
    end
    step();
    exp_v = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL skip_gap got %b exp %b", obs, exp_v); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_v = ev(2'd2, 1'b1, (k == 3), (k == 3), 1'b1);
      n_chk++; if (obs !== exp_v) $display("FAIL skip_ch2 cyc%0d got %b exp %b", k, obs, exp_v); else n_pass++;
    end
    step();
`ifdef SCAN_ONESHOT_EN
    exp_v = ev(2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL skip_oneshot_idle got %b exp %b", obs, exp_v); else n_pass++;
`else
    exp_v = ev(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL skip_wrap_gap got %b exp %b", obs, exp_v); else n_pass++;
    step();
    exp_v = ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL skip_wrap_ch0 got %b exp %b", obs, exp_v); else n_pass++;
`endif
    halt();
  endtask

  task automatic test_mux();
    logic [3:0] want;
    want = 4'b1100;
    mux_a = 1'b0; mux_b = 1'b0; mux_c = 1'b1; mux_d = 1'b1;
    sif.chan_en = 4'b1111;
    sif.dwell = 4'd1;
    kick();
    for (int ch = 0; ch < 4; ch++) begin
      step();
      n_chk++; if ({sif.sel, sif.sel_valid, sif.sample} !== {2'(ch), 2'b10})
        $display("FAIL mux_first ch%0d got %b exp %b", ch, {sif.sel, sif.sel_valid, sif.sample}, {2'(ch), 2'b10});
      else n_pass++;
      step();
      n_chk++; if ({sif.sample, mux_out} !== {1'b1, want[ch]})
        $display("FAIL mux_out ch%0d got %b exp %b", ch, {sif.sample, mux_out}, {1'b1, want[ch]});
      else n_pass++;
      if (ch < 3) step();
    end
    halt();
  endtask

  task automatic test_stop();
    sif.chan_en = 4'b1111;
    sif.dwell = 4'd7;
    kick();
    for (int k = 0; k < 8; k++) step();
    exp_v = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL stop_ch0_end got %b exp %b", obs, exp_v); else n_pass++;
    for (int k = 0; k < 4; k++) step();
    exp_v = ev(2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL stop_ch1_cyc3 got %b exp %b", obs, exp_v); else n_pass++;
    halt();
    exp_v = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL stop_idle got %b exp %b", obs, exp_v); else n_pass++;
    kick();
    exp_v = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL stop_restart_seek got %b exp %b", obs, exp_v); else n_pass++;
    step();
    exp_v = ev(2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL stop_restart_ch0 got %b exp %b", obs, exp_v); else n_pass++;
    halt();
  endtask

  task automatic test_no_enables();
    sif.chan_en = 4'b0000;
    sif.start = 1'b1;
    step();
    step();
    sif.start = 1'b0;
    exp_v = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL noen_start got %b exp %b", obs, exp_v); else n_pass++;
    sif.chan_en = 4'b0010;
    sif.dwell = 4'd2;
    kick();
    n_chk++; if (obs[3:0] !== 4'b0001) $display("FAIL noen_seek got %b exp 0001", obs[3:0]); else n_pass++;
    step();
    sif.chan_en = 4'b0000;
    step();
    exp_v = ev(2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL noen_dwell_holds got %b exp %b", obs, exp_v); else n_pass++;
    step();
    exp_v = ev(2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL noen_dwell_end got %b exp %b", obs, exp_v); else n_pass++;
    step();
`ifndef SCAN_ONESHOT_EN
    exp_v = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL noen_seek_gap got %b exp %b", obs, exp_v); else n_pass++;
    step();
`endif
    exp_v = ev(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL noen_back_idle got %b exp %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_async_reset();
    sif.chan_en = 4'b1111;
    sif.dwell = 4'd3;
    kick();
    for (int k = 0; k < 11; k++) step();
    exp_v = ev(2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL arst_pre got %b exp %b", obs, exp_v); else n_pass++;
    #2 rst = 1'b1;
    #1;
    exp_v = ev(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL arst_immediate got %b exp %b", obs, exp_v); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    step();
    n_chk++; if (obs !== exp_v) $display("FAIL arst_after_release got %b exp %b", obs, exp_v); else n_pass++;
  endtask

  task automatic test_sweep_mode();
    sif.chan_en = 4'b1001;
    sif.dwell = 4'd0;
    kick();
    step();
    exp_v = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL sweep_ch0 got %b exp %b", obs, exp_v); else n_pass++;
    step();
    step();
    exp_v = ev(2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL sweep_ch3 got %b exp %b", obs, exp_v); else n_pass++;
    step();
`ifdef SCAN_ONESHOT_EN
    exp_v = ev(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (obs !== exp_v) $display("FAIL oneshot_idle got %b exp %b", obs, exp_v); else n_pass++;
    step();
    step();
    n_chk++; if (obs !== exp_v) $display("FAIL oneshot_stays_idle got %b exp %b", obs, exp_v); else n_pass++;
`else
    exp_v = ev(2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL cont_gap got %b exp %b", obs, exp_v); else n_pass++;
    step();
    exp_v = ev(2'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_chk++; if (obs !== exp_v) $display("FAIL cont_resweep got %b exp %b", obs, exp_v); else n_pass++;
`endif
    halt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_chk = 0;
    n_pass = 0;
    mux_a = 1'b0; mux_b = 1'b0; mux_c = 1'b0; mux_d = 1'b0;
    sif.start = 1'b0;
    sif.stop = 1'b0;
    sif.chan_en = 4'b0000;
    sif.dwell = 4'd0;
    @(negedge clk);
    test_reset();
    test_dwell0();
    test_skip_dwell();
    test_mux();
    test_stop();
    test_no_enables();
    test_async_reset();
    test_sweep_mode();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
